// File: rtl/pipeline_scoreboard_pkg.sv
// Shared types for the ID-stage hazard scoreboard and its multi-cycle unit tracker.
package pipeline_scoreboard_pkg;

  localparam int MC_LATENCY_DEF = 4;
  // Wide enough to hold MC_LATENCY-1 for the largest legal latency of 16.
  localparam int MC_CNT_W       = 4;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_LOAD = 2'b01,
    KIND_MC   = 2'b10,
    KIND_RSVD = 2'b11
  } id_kind_e;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/pipeline_scoreboard_mc_tracker.sv
// Tracks the single in-flight multi-cycle op: an occupancy FSM, a latency countdown
// and the destination register captured when the op issued.
module mc_tracker
  import pipeline_scoreboard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MC_LATENCY = MC_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mc_issue,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              mc_busy,
  output logic              mc_wb_valid,
  output logic [REG_AW-1:0] mc_wb_rd
);

  localparam logic [MC_CNT_W-1:0] RELOAD = MC_CNT_W'(MC_LATENCY - 1);

  mc_state_e           state;
  logic [MC_CNT_W-1:0] count;
  logic [REG_AW-1:0]   rd_q;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MC_IDLE;
      count <= '0;
      rd_q  <= '0;
    end else if (mc_issue) begin
      // A new op may only issue while idle or in the writeback cycle, so this is a clean reload.
      state <= MC_BUSY;
      count <= RELOAD;
      rd_q  <= issue_rd;
    end else if (state == MC_BUSY) begin
      if (count == '0) state <= MC_IDLE;
      else             count <= count - 1'b1;
    end
  end

  assign mc_busy     = (state == MC_BUSY);
  assign mc_wb_valid = (state == MC_BUSY) && (count == '0);
  assign mc_wb_rd    = mc_wb_valid ? rd_q : '0;

endmodule

// File: rtl/pipeline_scoreboard.sv
// ID-stage hazard unit: pending-register scoreboard for LOAD/MC results, stall/flush
// control, multi-cycle unit occupancy and a saturating stall counter.
module pipeline_scoreboard
  import pipeline_scoreboard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MC_LATENCY = MC_LATENCY_DEF,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic [1:0]        id_kind,
  input  logic              flush,
  input  logic              ld_wb_valid,
  input  logic [REG_AW-1:0] ld_wb_rd,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              ctrl_sel,
  output logic              issue,
  output logic              mc_busy,
  output logic              mc_wb_valid,
  output logic [REG_AW-1:0] mc_wb_rd,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int NREG = 2 ** REG_AW;

  id_kind_e          kind;
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   clr_ld;
  logic [NREG-1:0]   clr_mc;
  logic [NREG-1:0]   set_pend;
  logic [NREG-1:0]   eff_pend;
  logic              raw_rs1;
  logic              raw_rs2;
  logic              waw_rd;
  logic              mc_struct;
  logic              stall;
  logic              is_mc;
  logic              marks_rd;
  logic [REG_AW-1:0] mc_issue_rd;

  assign kind  = id_kind_e'(id_kind);
  assign is_mc = (kind == KIND_MC);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    clr_ld   = '0;
    clr_mc   = '0;
    set_pend = '0;
    if (ld_wb_valid) clr_ld[ld_wb_rd] = 1'b1;
    if (mc_wb_valid) clr_mc[mc_wb_rd] = 1'b1;
    if (marks_rd)    set_pend[id_rd]  = 1'b1;
  end

  // Results in WB this cycle are forwarded, so they no longer block; x0 is never pending.
  assign eff_pend  = pend & ~clr_ld & ~clr_mc & ~NREG'(1);

  assign raw_rs1   = id_rs1_used  & eff_pend[id_rs1];
  assign raw_rs2   = id_rs2_used  & eff_pend[id_rs2];
  assign waw_rd    = id_reg_write & eff_pend[id_rd];
  assign mc_struct = is_mc & mc_busy & ~mc_wb_valid;

  assign stall       = id_valid & ~flush & (raw_rs1 | raw_rs2 | waw_rd | mc_struct);
  assign issue       = id_valid & ~stall & ~flush;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;
  assign ctrl_sel    = flush | (id_valid & ~issue);

  assign marks_rd    = issue & id_reg_write & (id_rd != '0) & ((kind == KIND_LOAD) | is_mc);
  assign mc_issue_rd = id_reg_write ? id_rd : '0;

  // NOTE: pend is a flop vector rather than a RAM, so resetting it asynchronously is legal and cheap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend        <= '0;
      stall_count <= '0;
    end else begin
      // OR-ing the set after the clears lets a new producer win over a same-cycle writeback.
      pend <= (pend & ~clr_ld & ~clr_mc) | set_pend;
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

  mc_tracker #(
    .REG_AW     (REG_AW),
    .MC_LATENCY (MC_LATENCY)
  ) u_mc_tracker (
    .clk         (clk),
    .reset_n     (reset_n),
    .mc_issue    (issue & is_mc),
    .issue_rd    (mc_issue_rd),
    .mc_busy     (mc_busy),
    .mc_wb_valid (mc_wb_valid),
    .mc_wb_rd    (mc_wb_rd)
  );

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Bench for pipeline_scoreboard: scenario tasks check ID control inline; a queue of
// expected MC writebacks (rd, due cycle) is checked by a monitor each cycle.
module tb_pipeline_scoreboard;
  import pipeline_scoreboard_pkg::*;

  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 32;

  localparam logic [3:0] P_ISSUE = 4'b1101; // {pc_write, if_id_write, ctrl_sel, issue}
  localparam logic [3:0] P_STALL = 4'b0010;
  localparam logic [3:0] P_FLUSH = 4'b1110;
  localparam logic [3:0] P_IDLE  = 4'b1100;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, ld_wb_rd = '0;
  logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_reg_write = 1'b0;
  logic [1:0]    id_kind = 2'b00;
  logic          flush = 1'b0, ld_wb_valid = 1'b0;
  logic          pc_write, if_id_write, ctrl_sel, issue, mc_busy, mc_wb_valid;
  logic [AW-1:0] mc_wb_rd;
  logic [CW-1:0] stall_count;
  logic [3:0]    ctl;

  typedef struct {
    logic [AW-1:0] rd;
    int            due;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  wb_exp_t mon_e;
  logic    mon_exp;
  int      cyc    = 0;
  int      total  = 0;
  int      bad    = 0;
  int      exp_sc = 0;

  pipeline_scoreboard #(.REG_AW(AW), .MC_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_kind(id_kind), .flush(flush),
    .ld_wb_valid(ld_wb_valid), .ld_wb_rd(ld_wb_rd), .pc_write(pc_write),
    .if_id_write(if_id_write), .ctrl_sel(ctrl_sel), .issue(issue), .mc_busy(mc_busy),
    .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd), .stall_count(stall_count)
  );

  assign ctl = {pc_write, if_id_write, ctrl_sel, issue};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MC writeback monitor: each expected writeback must appear on its due cycle with its rd,
  // and no writeback may appear that was not expected.
  always @(negedge clk) begin
    #3;
    if (reset_n) begin
      mon_exp = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      if (mon_exp || mc_wb_valid) begin
        total++;
        if (!mon_exp) begin
          bad++;
          $display("FAIL mc_wb_unexpected cyc=%0d: mc_wb_valid=%b rd=%0d, want no writeback",
                   cyc, mc_wb_valid, mc_wb_rd);
        end else begin
          mon_e = sb_q.pop_front();
          if (mc_wb_valid !== 1'b1 || mc_wb_rd !== mon_e.rd) begin
            bad++;
            $display("FAIL mc_wb cyc=%0d: valid=%b rd=%0d, want valid=1 rd=%0d",
                     cyc, mc_wb_valid, mc_wb_rd, mon_e.rd);
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input id_kind_e k, input logic [AW-1:0] rd,
                       input logic wr, input logic [AW-1:0] r1, input logic u1,
                       input logic [AW-1:0] r2, input logic u2, input logic fl,
                       input logic lv, input logic [AW-1:0] lrd);
    @(negedge clk);
    id_valid = v; id_kind = k; id_rd = rd; id_reg_write = wr;
    id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    flush = fl; ld_wb_valid = lv; ld_wb_rd = lrd;
    #2;
  endtask

  task automatic nop();
    drive(0, KIND_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_wb(input logic [AW-1:0] rd);
    wb_exp_t e;
    e.rd  = rd;
    e.due = cyc + LAT;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (ctl !== P_IDLE || mc_busy !== 1'b0 || mc_wb_valid !== 1'b0 || mc_wb_rd !== '0 ||
        stall_count !== '0) begin
      bad++;
      $display("FAIL reset: ctl=%b busy=%b wbv=%b wbrd=%0d sc=%0d, want ctl=%b 0 0 0 0",
               ctl, mc_busy, mc_wb_valid, mc_wb_rd, stall_count, P_IDLE);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_load_use();
    drive(1, KIND_LOAD, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== P_ISSUE) begin bad++; $display("FAIL lu_load: ctl=%b want %b", ctl, P_ISSUE); end
    drive(1, KIND_ALU, 6, 1, 5, 1, 0, 0, 0, 0, 0);
    exp_sc++;
    total++;
    if (ctl !== P_STALL) begin bad++; $display("FAIL lu_stall: ctl=%b want %b", ctl, P_STALL); end
    drive(1, KIND_ALU, 6, 1, 5, 1, 0, 0, 0, 1, 5);
    total++;
    if (ctl !== P_ISSUE) begin bad++; $display("FAIL lu_wb_issue: ctl=%b want %b", ctl, P_ISSUE); end
    nop();
    total++;
    if (ctl !== P_IDLE || stall_count !== CW'(exp_sc)) begin
      bad++;
      $display("FAIL lu_count: ctl=%b sc=%0d, want %b sc=%0d", ctl, stall_count, P_IDLE, exp_sc);
    end
    drive(1, KIND_ALU, 6, 1, 5, 1, 5, 1, 0, 0, 0);
    total++;
    if (ctl !== P_ISSUE) begin bad++; $display("FAIL lu_cleared: ctl=%b want %b", ctl, P_ISSUE); end
  endtask

  task automatic test_mc_dep();
    drive(1, KIND_MC, 7, 1, 1, 1, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== P_ISSUE || mc_busy !== 1'b0) begin
      bad++; $display("FAIL mc_issue: ctl=%b busy=%b, want %b busy=0", ctl, mc_busy, P_ISSUE);
    end
    push_wb(7);
    for (int i = 1; i <= LAT; i++) begin
      drive(1, KIND_ALU, 8, 1, 0, 0, 7, 1, 0, 0, 0);
      total++;
      if (i < LAT) begin
        exp_sc++;
        if (ctl !== P_STALL || mc_busy !== 1'b1 || mc_wb_valid !== 1'b0) begin
          bad++;
          $display("FAIL mc_dep_stall c%0d: ctl=%b busy=%b wbv=%b, want %b 1 0",
                   i, ctl, mc_busy, mc_wb_valid, P_STALL);
        end
      end else if (ctl !== P_ISSUE || mc_wb_valid !== 1'b1 || mc_wb_rd !== 7) begin
        bad++;
        $display("FAIL mc_dep_issue: ctl=%b wbv=%b rd=%0d, want %b 1 7",
                 ctl, mc_wb_valid, mc_wb_rd, P_ISSUE);
      end
    end
    nop();
    total++;
    if (mc_busy !== 1'b0 || stall_count !== CW'(exp_sc)) begin
      bad++; $display("FAIL mc_dep_after: busy=%b sc=%0d, want 0 %0d", mc_busy, stall_count, exp_sc);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, KIND_MC, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== P_ISSUE) begin bad++; $display("FAIL b2b_first: ctl=%b want %b", ctl, P_ISSUE); end
    push_wb(8);
    for (int i = 1; i <= LAT; i++) begin
      drive(1, KIND_MC, 9, 1, 0, 0, 0, 0, 0, 0, 0);
      total++;
      if (i < LAT) begin
        exp_sc++;
        if (ctl !== P_STALL) begin bad++; $display("FAIL b2b_stall c%0d: ctl=%b want %b", i, ctl, P_STALL); end
      end else if (ctl !== P_ISSUE || mc_wb_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_second: ctl=%b wbv=%b, want %b 1", ctl, mc_wb_valid, P_ISSUE);
      end
    end
    push_wb(9);
    nop();
    total++;
    if (mc_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: busy=%b want 1", mc_busy); end
    for (int i = 0; i < LAT - 1; i++) nop();
    nop();
    total++;
    if (mc_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: busy=%b want 0", mc_busy); end
  endtask

  task automatic test_flush();
    drive(1, KIND_LOAD, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, KIND_ALU, 6, 1, 5, 1, 0, 0, 1, 0, 0);
    total++;
    if (ctl !== P_FLUSH) begin bad++; $display("FAIL flush_over_stall: ctl=%b want %b", ctl, P_FLUSH); end
    drive(1, KIND_ALU, 6, 1, 5, 1, 0, 0, 0, 0, 0);
    exp_sc++;
    total++;
    if (ctl !== P_STALL || stall_count !== CW'(exp_sc - 1)) begin
      bad++;
      $display("FAIL flush_pend_kept: ctl=%b sc=%0d, want %b sc=%0d", ctl, stall_count, P_STALL, exp_sc - 1);
    end
    drive(1, KIND_ALU, 6, 1, 5, 1, 0, 0, 0, 1, 5);
    total++;
    if (ctl !== P_ISSUE) begin bad++; $display("FAIL flush_release: ctl=%b want %b", ctl, P_ISSUE); end
    // A flush while the MC unit is busy must not cancel the op in flight.
    drive(1, KIND_MC, 11, 1, 0, 0, 0, 0, 0, 0, 0);
    push_wb(11);
    drive(0, KIND_ALU, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    total++;
    if (ctl !== P_FLUSH || mc_busy !== 1'b1) begin
      bad++; $display("FAIL flush_mc: ctl=%b busy=%b, want %b 1", ctl, mc_busy, P_FLUSH);
    end
    for (int i = 0; i < LAT; i++) nop();
  endtask

  task automatic test_waw_rsvd();
    drive(1, KIND_LOAD, 12, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, KIND_ALU, 12, 1, 0, 0, 0, 0, 0, 0, 0);
    exp_sc++;
    total++;
    if (ctl !== P_STALL) begin bad++; $display("FAIL waw_stall: ctl=%b want %b", ctl, P_STALL); end
    // WB of x12 this cycle lets a new LOAD to x12 issue; its set must beat the clear.
    drive(1, KIND_LOAD, 12, 1, 0, 0, 0, 0, 0, 1, 12);
    total++;
    if (ctl !== P_ISSUE) begin bad++; $display("FAIL waw_wb_issue: ctl=%b want %b", ctl, P_ISSUE); end
    drive(1, KIND_ALU, 3, 1, 12, 1, 0, 0, 0, 0, 0);
    exp_sc++;
    total++;
    if (ctl !== P_STALL) begin bad++; $display("FAIL set_wins: ctl=%b want %b", ctl, P_STALL); end
    drive(1, KIND_ALU, 3, 1, 12, 1, 0, 0, 0, 1, 12);
    drive(1, KIND_RSVD, 13, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, KIND_ALU, 3, 1, 13, 1, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== P_ISSUE) begin bad++; $display("FAIL rsvd_as_alu: ctl=%b want %b", ctl, P_ISSUE); end
    drive(1, KIND_MC, 14, 0, 0, 0, 0, 0, 0, 0, 0);
    push_wb(0);
    drive(1, KIND_ALU, 3, 1, 14, 1, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== P_ISSUE || mc_busy !== 1'b1) begin
      bad++; $display("FAIL mc_nowrite: ctl=%b busy=%b, want %b 1", ctl, mc_busy, P_ISSUE);
    end
    for (int i = 0; i < LAT; i++) nop();
  endtask

  task automatic test_x0();
    drive(1, KIND_LOAD, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, KIND_ALU, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    total++;
    if (ctl !== P_ISSUE || dut.pend !== '0) begin
      bad++; $display("FAIL x0: ctl=%b pend=%h, want %b pend=0", ctl, dut.pend, P_ISSUE);
    end
  endtask

  task automatic test_reset_mid_mc();
    drive(1, KIND_MC, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    push_wb(7);
    nop();
    nop();
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (mc_busy !== 1'b0 || mc_wb_valid !== 1'b0 || mc_wb_rd !== '0 || stall_count !== '0 ||
        dut.pend !== '0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b wbv=%b rd=%0d sc=%0d pend=%h, want all 0",
               mc_busy, mc_wb_valid, mc_wb_rd, stall_count, dut.pend);
    end
    sb_q.delete();
    exp_sc = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) nop();
    drive(1, KIND_ALU, 3, 1, 7, 1, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== P_ISSUE || mc_busy !== 1'b0) begin
      bad++; $display("FAIL reset_after: ctl=%b busy=%b, want %b 0", ctl, mc_busy, P_ISSUE);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mc_dep();
    test_back_to_back();
    test_flush();
    test_waw_rsvd();
    test_x0();
    test_reset_mid_mc();
    nop();
    total++;
    if (sb_q.size() != 0 || stall_count !== CW'(exp_sc)) begin
      bad++;
      $display("FAIL final: pending_wb=%0d sc=%0d, want 0 sc=%0d", sb_q.size(), stall_count, exp_sc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
